// File: rtl/pillar_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM encoding and width helpers.
package pillar_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Index width that stays legal (>=1) even for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the N request ports and the single RAM port of the memory-bus arbiter.
interface mem_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  import pillar_bus_pkg::*;

  localparam int STRB_W = strb_w(DATA_W);

  logic [N_MASTERS-1:0]        req_valid;
  logic [N_MASTERS-1:0]        req_ready;
  logic [N_MASTERS-1:0]        req_we;
  logic [N_MASTERS*ADDR_W-1:0] req_addr;
  logic [N_MASTERS*DATA_W-1:0] req_wdata;
  logic [N_MASTERS*STRB_W-1:0] req_wstrb;
  logic [N_MASTERS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;

  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [STRB_W-1:0]           mem_wstrb;
  logic [DATA_W-1:0]           mem_rdata;

  // Requesters and the RAM model sit on the master side; the arbiter is the slave.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or above last_grant+1 (mod N) wins.
module rr_arbiter
  import pillar_bus_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             update_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] last_q, last_d;

  always_comb begin : search
    int               cand;
    logic [IDX_W-1:0] cidx;
    logic             found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_q) + k) % N;
      cidx = IDX_W'(cand);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        gnt_o[cidx] = 1'b1;
        gnt_idx_o   = cidx;
      end
    end
  end

  assign last_d = update_i ? gnt_idx_o : last_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IDX_W'(N - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to single synchronous RAM arbiter: IDLE -> ISSUE -> RESP, one transaction at a time.
module mem_bus_arbiter
  import pillar_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int IDX_W  = idx_w(N_MASTERS);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic [N_MASTERS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 grant_en;

  assign grant_en = (state_q == ST_IDLE) && (|bus.req_valid) && !reset;

  rr_arbiter #(.N(N_MASTERS)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    (bus.req_valid),
    .update_i (grant_en),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next state, and capture of the winner's payload on the IDLE handshake.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_d = ST_ISSUE;
          win_d   = gnt_idx;
          we_d    = bus.req_we[gnt_idx];
          addr_d  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
          wstrb_d = bus.req_wstrb[gnt_idx*STRB_W +: STRB_W];
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Everything except req_ready is decoded from registered state.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!reset) bus.req_ready = gnt;
      end
      ST_ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = we_q ? wstrb_q : '0;
      end
      ST_RESP: begin
        bus.rsp_valid[win_q] = 1'b1;
        bus.rsp_rdata        = bus.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
